// File: rtl/garage_door_plant.sv
// rtl/garage_door_plant.sv - garage door actuator plant: position tracking, limit switches, drive fault
module garage_door_plant #(
    parameter int TRAVEL_TICKS = 16,
    parameter int STEP_DIV     = 4,
    parameter int POS_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             Up_MAX,
    output logic             Dn_MAX,
    output logic [POS_W-1:0] Position,
    output logic             Moving,
    output logic             Fault
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [POS_W-1:0] TOP      = POS_W'(TRAVEL_TICKS);
    localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_t;

    dir_t             drive;
    dir_t             last_dir;
    dir_t             last_dir_nxt;
    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [PW-1:0]    pre_base;
    logic [POS_W-1:0] pos_nxt;
    logic             moving_nxt;
    logic             fault_nxt;
    logic             can_step;

    always_comb begin
        drive = DIR_NONE;
        if (UP_M && !DN_M) begin
            drive = DIR_UP;
        end else if (DN_M && !UP_M) begin
            drive = DIR_DN;
        end
    end

    assign can_step = ((drive == DIR_UP) && (Position < TOP)) ||
                      ((drive == DIR_DN) && (Position != '0));

    always_comb begin
        pos_nxt      = Position;
        pre_nxt      = '0;
        pre_base     = pre;
        last_dir_nxt = DIR_NONE;
        moving_nxt   = 1'b0;
        fault_nxt    = Fault;
        if (Fault) begin
            pre_base = '0;
        end else if (UP_M && DN_M) begin
            fault_nxt = 1'b1;
        end else if (drive != DIR_NONE) begin
            last_dir_nxt = drive;
            if (can_step) begin
                moving_nxt = 1'b1;
                // A reversal restarts the count with this edge as the first one
                if ((last_dir != DIR_NONE) && (last_dir != drive)) begin
                    pre_base = '0;
                end
                if (pre_base == PRE_LAST) begin
                    pre_nxt = '0;
                    pos_nxt = (drive == DIR_UP) ? Position + 1'b1 : Position - 1'b1;
                end else begin
                    pre_nxt = pre_base + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Position <= '0;
            pre      <= '0;
            last_dir <= DIR_NONE;
            Moving   <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            Position <= pos_nxt;
            pre      <= pre_nxt;
            last_dir <= last_dir_nxt;
            Moving   <= moving_nxt;
            Fault    <= fault_nxt;
        end
    end

    assign Up_MAX = (Position == TOP);
    assign Dn_MAX = (Position == '0);

endmodule

// File: tb/tb_garage_door_plant.sv
// tb/tb_garage_door_plant.sv - randomized self-checking bench for garage_door_plant
module tb_garage_door_plant;

    localparam int T  = 16;
    localparam int S  = 4;
    localparam int PW = 8;

    logic          CLK  = 1'b0;
    logic          RST  = 1'b1;
    logic          UP_M = 1'b0;
    logic          DN_M = 1'b0;
    logic          Up_MAX;
    logic          Dn_MAX;
    logic [PW-1:0] Position;
    logic          Moving;
    logic          Fault;

    garage_door_plant #(
        .TRAVEL_TICKS(T),
        .STEP_DIV    (S),
        .POS_W       (PW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .UP_M    (UP_M),
        .DN_M    (DN_M),
        .Up_MAX  (Up_MAX),
        .Dn_MAX  (Dn_MAX),
        .Position(Position),
        .Moving  (Moving),
        .Fault   (Fault)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 0;

    // Model: door position plus the number of driving edges spent in the current run
    int m_pos;
    int m_cnt;
    int m_run;
    bit m_moving;
    bit m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_cnt    = 0;
        m_run    = 0;
        m_moving = 0;
        m_fault  = 0;
    endtask

    task automatic model_step(input bit up, input bit dn);
        int d;
        d = up ? 1 : (dn ? -1 : 0);
        m_moving = 0;
        if (m_fault) begin
            m_cnt = 0;
        end else if (up && dn) begin
            m_fault = 1;
            m_cnt   = 0;
            m_run   = 0;
        end else if (d == 0) begin
            m_cnt = 0;
            m_run = 0;
        end else begin
            if (d != m_run) m_cnt = 0;
            m_run = d;
            if ((d == 1 && m_pos == T) || (d == -1 && m_pos == 0)) begin
                m_cnt = 0;
            end else begin
                m_moving = 1;
                m_cnt++;
                if (m_cnt == S) begin
                    m_pos = m_pos + d;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit up, input bit dn);
        @(negedge CLK);
        UP_M = up;
        DN_M = dn;
        @(posedge CLK);
        model_step(up, dn);
        #1;
    endtask

    task automatic run(input bit up, input bit dn, input int n);
        repeat (n) cyc(up, dn);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        UP_M = 0;
        DN_M = 0;
        #2;
        RST = 0;
        model_reset();
        #1;
        check("async_rst_pos", 32'(Position), 0);
        check("async_rst_dnmax", 32'(Dn_MAX), 1);
        repeat (2) @(negedge CLK);
        RST = 1;
    endtask

    always @(negedge CLK) begin
        if (!done) begin
            check("outputs", {20'd0, Up_MAX, Dn_MAX, Position, Moving, Fault},
                  {20'd0, m_pos == T, m_pos == 0, PW'(m_pos), m_moving, m_fault});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int len;
        model_reset();
        #1;
        RST = 0;
        repeat (3) @(negedge CLK);
        RST = 1;

        run(0, 0, 20);
        check("idle_pos", 32'(Position), 0);
        check("idle_dnmax", 32'(Dn_MAX), 1);
        check("idle_upmax", 32'(Up_MAX), 0);
        check("idle_fault", 32'(Fault), 0);

        cyc(1, 0);
        check("up_edge1_moving", 32'(Moving), 1);
        run(1, 0, 2);
        check("up_edge3_pos", 32'(Position), 0);
        cyc(1, 0);
        check("up_edge4_pos", 32'(Position), 1);
        check("up_edge4_dnmax", 32'(Dn_MAX), 0);
        run(1, 0, 60);
        check("up_edge64_pos", 32'(Position), 16);
        check("up_edge64_upmax", 32'(Up_MAX), 1);

        run(1, 0, 10);
        check("top_hold_pos", 32'(Position), 16);
        check("top_hold_moving", 32'(Moving), 0);
        check("top_hold_fault", 32'(Fault), 0);
        run(0, 1, 4);
        check("dn_edge4_upmax", 32'(Up_MAX), 0);
        run(0, 1, 60);
        check("dn_edge64_dnmax", 32'(Dn_MAX), 1);

        run(1, 0, 6);
        check("partial_pos", 32'(Position), 1);
        cyc(0, 0);
        run(0, 1, 4);
        check("after_gap_pos", 32'(Position), 0);
        run(1, 0, 6);
        run(0, 1, 3);
        check("reverse_edge3_pos", 32'(Position), 1);
        cyc(0, 1);
        check("reverse_edge4_pos", 32'(Position), 0);

        run(1, 0, 20);
        check("pre_fault_pos", 32'(Position), 5);
        cyc(1, 1);
        check("fault_set", 32'(Fault), 1);
        for (int i = 0; i < 8; i++) cyc(1'($urandom), 1'($urandom));
        check("fault_pos_frozen", 32'(Position), 5);
        check("fault_not_moving", 32'(Moving), 0);
        check("fault_sticky", 32'(Fault), 1);
        do_reset();
        check("fault_cleared", 32'(Fault), 0);

        run(1, 0, 34);
        check("mid_pos", 32'(Position), 8);
        do_reset();
        run(1, 0, 3);
        check("discarded_pre_pos", 32'(Position), 0);
        cyc(1, 0);
        check("fresh_step_pos", 32'(Position), 1);

        for (int s = 0; s < 150; s++) begin
            r   = $urandom_range(0, 99);
            len = $urandom_range(1, 40);
            if (r < 45)      run(1, 0, len);
            else if (r < 88) run(0, 1, len);
            else if (r < 97) run(0, 0, len);
            else             cyc(1, 1);
            if (m_fault && $urandom_range(0, 2) == 0) do_reset();
            else if ($urandom_range(0, 60) == 0) do_reset();
        end

        @(negedge CLK);
        #1;
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
